// File: rtl/prog_pkg.sv
// Shared definitions for the programming path: command bytes and loader FSM encoding.
// The I2C slave and the processor import this package as well.
package prog_pkg;

    localparam logic [7:0] PROG_CMD_PROG = 8'hA5;
    localparam logic [7:0] PROG_CMD_RUN  = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_SKIP = 3'd4
    } prog_state_e;

endpackage

// File: rtl/prog_loader.sv
// Loads program bytes received over I2C into an external program memory
// and gates the processor run signal.
//
// state | meaning
// IDLE  | bus idle or foreign traffic; waiting for START
// CMD   | next byte is the command
// ADDR  | next byte is the start address
// DATA  | bytes are written to memory at the auto-incrementing pointer
// SKIP  | remaining bytes of this transaction are discarded
module prog_loader
    import prog_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter logic [7:0]  CMD_PROG = PROG_CMD_PROG,
    parameter logic [7:0]  CMD_RUN  = PROG_CMD_RUN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_start,
    input  logic              rx_stop,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic [7:0]        checksum,
    output logic              err_cmd,
    output logic              err_ovf
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    prog_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_run_q, cpu_run_d;
    logic [7:0]        checksum_q, checksum_d;
    logic              err_cmd_q, err_cmd_d;
    logic              err_ovf_q, err_ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            checksum_q  <= '0;
            err_cmd_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            checksum_q  <= checksum_d;
            err_cmd_q   <= err_cmd_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_run_d   = cpu_run_q;
        checksum_d  = checksum_q;
        err_cmd_d   = err_cmd_q;
        err_ovf_d   = err_ovf_q;

        // A (repeated) START overrides both a colliding byte and a colliding STOP.
        if (rx_start) begin
            state_d = ST_CMD;
        end else begin
            if (rx_valid) begin
                case (state_q)
                    ST_CMD: begin
                        if (rx_data == CMD_PROG) begin
                            state_d    = ST_ADDR;
                            checksum_d = '0;
                            cpu_run_d  = 1'b0;
                            err_ovf_d  = 1'b0;
                            cnt_d      = '0;
                        end else if (rx_data == CMD_RUN) begin
                            cpu_run_d = 1'b1;
                            state_d   = ST_SKIP;
                        end else begin
                            err_cmd_d = 1'b1;
                            state_d   = ST_SKIP;
                        end
                    end
                    ST_ADDR: begin
                        ptr_d   = rx_data[ADDR_W-1:0];
                        state_d = ST_DATA;
                    end
                    ST_DATA: begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = rx_data;
                        ptr_d       = ptr_q + PTR_ONE;
                        checksum_d  = checksum_q + rx_data;
                        // cnt_q already counts DEPTH bytes: this one overflows.
                        if (cnt_q >= CNT_DEPTH) begin
                            err_ovf_d = 1'b1;
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (rx_stop) begin
                state_d = ST_IDLE;
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_run   = cpu_run_q;
    assign checksum  = checksum_q;
    assign err_cmd   = err_cmd_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a vector table for the byte-level protocol
// plus hand-written overflow and mid-transaction reset sequences.
module tb_prog_loader;

    logic       clk;
    logic       rst;
    logic       rx_start;
    logic       rx_stop;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic [7:0] checksum;
    logic       err_cmd;
    logic       err_ovf;

    int total = 0;
    int bad   = 0;

    prog_loader #(
        .ADDR_W  (4),
        .CMD_PROG(8'hA5),
        .CMD_RUN (8'h5A)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_start (rx_start),
        .rx_stop  (rx_stop),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_run  (cpu_run),
        .checksum (checksum),
        .err_cmd  (err_cmd),
        .err_ovf  (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       p;
        logic       v;
        logic [7:0] d;
        logic       we;
        logic [3:0] a;
        logic [7:0] wd;
        logic       run;
        logic [7:0] cs;
        logic       ec;
        logic       eo;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic p, input logic v, input logic [7:0] d,
                       input logic we, input logic [3:0] a, input logic [7:0] wd,
                       input logic run, input logic [7:0] cs, input logic ec, input logic eo);
        vec_t t;
        t.s = s; t.p = p; t.v = v; t.d = d;
        t.we = we; t.a = a; t.wd = wd;
        t.run = run; t.cs = cs; t.ec = ec; t.eo = eo;
        vq.push_back(t);
    endtask

    task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk(input int idx, input logic we, input logic [3:0] a, input logic [7:0] wd,
                       input logic run, input logic [7:0] cs, input logic ec, input logic eo);
        cmp("mem_we", idx, 32'(mem_we), 32'(we));
        if (we) begin
            cmp("mem_addr", idx, 32'(mem_addr), 32'(a));
            cmp("mem_wdata", idx, 32'(mem_wdata), 32'(wd));
        end
        cmp("cpu_run", idx, 32'(cpu_run), 32'(run));
        cmp("checksum", idx, 32'(checksum), 32'(cs));
        cmp("err_cmd", idx, 32'(err_cmd), 32'(ec));
        cmp("err_ovf", idx, 32'(err_ovf), 32'(eo));
    endtask

    task automatic step(input logic s, input logic p, input logic v, input logic [7:0] d);
        rx_start = s;
        rx_stop  = p;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cs;
        int idx;

        rst = 1'b1; rx_start = 1'b0; rx_stop = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #2;
        chk(0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cmp("rst_addr", 0, 32'(mem_addr), 32'h0);
        cmp("rst_wdata", 0, 32'(mem_wdata), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // basic write: (3,11) (4,22), idle byte ignored
        add(1,0,0,8'h00, 0,0,0, 0,8'h00,0,0);
        add(0,0,1,8'hA5, 0,0,0, 0,8'h00,0,0);
        add(0,0,1,8'h03, 0,0,0, 0,8'h00,0,0);
        add(0,0,1,8'h11, 1,3,8'h11, 0,8'h11,0,0);
        add(0,0,0,8'h00, 0,0,0, 0,8'h11,0,0);
        add(0,0,1,8'h22, 1,4,8'h22, 0,8'h33,0,0);
        add(0,1,0,8'h00, 0,0,0, 0,8'h33,0,0);
        add(0,0,1,8'h55, 0,0,0, 0,8'h33,0,0);
        // address wrap 15 -> 0, stop with byte in the same cycle
        add(1,0,0,8'h00, 0,0,0, 0,8'h33,0,0);
        add(0,0,1,8'hA5, 0,0,0, 0,8'h00,0,0);
        add(0,0,1,8'h0F, 0,0,0, 0,8'h00,0,0);
        add(0,0,1,8'h01, 1,15,8'h01, 0,8'h01,0,0);
        add(0,0,1,8'h02, 1,0,8'h02, 0,8'h03,0,0);
        add(0,1,1,8'h04, 1,1,8'h04, 0,8'h07,0,0);
        add(0,0,1,8'h09, 0,0,0, 0,8'h07,0,0);
        // run, then program clears run, then unknown command
        add(1,0,0,8'h00, 0,0,0, 0,8'h07,0,0);
        add(0,0,1,8'h5A, 0,0,0, 1,8'h07,0,0);
        add(0,1,0,8'h00, 0,0,0, 1,8'h07,0,0);
        add(0,0,0,8'h00, 0,0,0, 1,8'h07,0,0);
        add(1,0,0,8'h00, 0,0,0, 1,8'h07,0,0);
        add(0,0,1,8'hA5, 0,0,0, 0,8'h00,0,0);
        add(1,0,0,8'h00, 0,0,0, 0,8'h00,0,0);
        add(0,0,1,8'h77, 0,0,0, 0,8'h00,1,0);
        add(0,0,1,8'h10, 0,0,0, 0,8'h00,1,0);
        add(0,1,0,8'h00, 0,0,0, 0,8'h00,1,0);
        // repeated start colliding with a data byte
        add(1,0,0,8'h00, 0,0,0, 0,8'h00,1,0);
        add(0,0,1,8'hA5, 0,0,0, 0,8'h00,1,0);
        add(0,0,1,8'h02, 0,0,0, 0,8'h00,1,0);
        add(0,0,1,8'h44, 1,2,8'h44, 0,8'h44,1,0);
        add(1,0,1,8'h66, 0,0,0, 0,8'h44,1,0);
        add(0,0,1,8'hA5, 0,0,0, 0,8'h00,1,0);
        add(0,0,1,8'h08, 0,0,0, 0,8'h00,1,0);
        add(0,0,1,8'h99, 1,8,8'h99, 0,8'h99,1,0);
        add(0,1,0,8'h00, 0,0,0, 0,8'h99,1,0);
        // start and stop together: start wins, next byte is a command
        add(1,1,0,8'h00, 0,0,0, 0,8'h99,1,0);
        add(0,0,1,8'h5A, 0,0,0, 1,8'h99,1,0);
        add(0,1,0,8'h00, 0,0,0, 1,8'h99,1,0);

        idx = 1;
        foreach (vq[i]) begin
            step(vq[i].s, vq[i].p, vq[i].v, vq[i].d);
            chk(idx, vq[i].we, vq[i].a, vq[i].wd, vq[i].run, vq[i].cs, vq[i].ec, vq[i].eo);
            idx++;
        end

        // overflow: 16 bytes fill memory, the 17th and 18th wrap and flag
        idx = 1000;
        step(1'b1, 1'b0, 1'b0, 8'h00); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hA5); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'(i + 1));
            cs = cs + 8'(i + 1);
            chk(idx++, 1'b1, 4'(i), 8'(i + 1), 1'b0, cs, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 8'h11); chk(idx++, 1'b1, 4'h0, 8'h11, 1'b0, 8'h99, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h20); chk(idx++, 1'b1, 4'h1, 8'h20, 1'b0, 8'hB9, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'hB9, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'hB9, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'hA5); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

        // reset between two data bytes
        idx = 2000;
        step(1'b1, 1'b0, 1'b0, 8'h00); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hA5); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h05); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h12); chk(idx++, 1'b1, 4'h5, 8'h12, 1'b0, 8'h12, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk(idx, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cmp("async_addr", idx, 32'(mem_addr), 32'h0);
        cmp("async_wdata", idx, 32'(mem_wdata), 32'h0);
        idx++;
        #1 rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 8'h34); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h56); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hA5); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h01); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h77); chk(idx++, 1'b1, 4'h1, 8'h77, 1'b0, 8'h77, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00); chk(idx++, 1'b0, 4'h0, 8'h00, 1'b0, 8'h77, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 4: program-memory address width; depth = 2**ADDR_W.
REQ-002 Parameter CMD_PROG, default 8'hA5: command byte that opens a program-write transaction.
REQ-003 Parameter CMD_RUN, default 8'h5A: command byte that releases the processor.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rx_start  in  1  one-cycle strobe: I2C START or repeated START addressed to the programming port.
REQ-007 rx_stop  in  1  one-cycle strobe: I2C STOP seen.
REQ-008 rx_valid  in  1  one-cycle strobe: rx_data holds a complete received byte.
REQ-009 rx_data  in  8  received byte, sampled only while rx_valid=1.
REQ-010 mem_we  out  1  one-cycle program-memory write strobe.
REQ-011 mem_addr  out  ADDR_W  write address, valid while mem_we=1.
REQ-012 mem_wdata  out  8  write data, valid while mem_we=1.
REQ-013 cpu_run  out  1  level signal; 1 releases the processor, 0 holds it.
REQ-014 checksum  out  8  modulo-256 sum of the data bytes in the current or last program transaction.
REQ-015 err_cmd  out  1  sticky flag: an unknown command byte was received.
REQ-016 err_ovf  out  1  sticky flag: a transaction wrote more than 2**ADDR_W data bytes.

Function
REQ-017 FSM states: IDLE, CMD, ADDR, DATA, SKIP.
REQ-018 In IDLE, rx_valid is ignored; rx_start moves the FSM to CMD.
REQ-019 In CMD, a byte equal to CMD_PROG moves to ADDR, clears checksum, clears cpu_run and clears err_ovf.
REQ-020 In CMD, a byte equal to CMD_RUN sets cpu_run and moves to SKIP.
REQ-021 In CMD, any other byte sets err_cmd and moves to SKIP.
REQ-022 In ADDR, the low ADDR_W bits of the byte load the address pointer, the upper bits are ignored, and the FSM moves to DATA.
REQ-023 In DATA, each rx_valid causes, on the next cycle: mem_we=1, mem_addr=pointer, mem_wdata=byte; the pointer then increments modulo 2**ADDR_W (wrap to 0) and checksum += byte (mod 256).
REQ-024 Write latency is exactly one clock from the rx_valid edge to the mem_we cycle; mem_we is never high for two consecutive cycles from a single byte.
REQ-025 A per-transaction data counter (ADDR_W+1 bits, saturating) sets err_ovf when the (2**ADDR_W+1)th byte arrives; that byte and all later bytes are still written, with wrap-around.
REQ-026 In SKIP, received bytes are discarded.
REQ-027 rx_stop in any state returns the FSM to IDLE; a write already scheduled by the preceding rx_valid still completes.
REQ-028 rx_start in any state returns the FSM to CMD (repeated START).
REQ-029 If rx_start and rx_valid occur in the same cycle, rx_start wins and the byte is dropped.
REQ-030 If rx_stop and rx_valid occur in the same cycle, the byte is processed first and the FSM then enters IDLE.
REQ-031 If rx_start and rx_stop occur in the same cycle, rx_start wins.
REQ-032 cpu_run is 0 throughout every program transaction and stays 1 after CMD_RUN until the next CMD_PROG or rst.
REQ-033 err_cmd clears only on rst.

Reset
REQ-034 rst=1 forces asynchronously: state=IDLE, pointer=0, data counter=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, checksum=0, err_cmd=0, err_ovf=0.
REQ-035 rst asserted mid-transaction aborts it with no further mem_we; after rst is released the block waits for a fresh rx_start.

Structure
REQ-036 The command-byte constants and the FSM state encoding belong in a shared package, prog_pkg, which is also used by the I2C slave and the processor.
REQ-037 The block is a single module with no sub-modules; the program memory stays outside it, in the top level.

Verification
REQ-038 start, 0xA5, 0x03, 0x11, 0x22, stop -> writes (3,0x11) and (4,0x22), each one cycle after its rx_valid; checksum=0x33; cpu_run=0.
REQ-039 With ADDR_W=4: start, 0xA5, 0x0F, 0x01, 0x02, stop -> writes (15,0x01) then (0,0x02); err_ovf=0.
REQ-040 start, 0xA5, 0x00, then 17 data bytes -> 17 writes; the 17th goes to address 0; err_ovf=1 from the cycle the 17th byte arrives.
REQ-041 start, 0x5A, stop -> cpu_run=1; then start, 0xA5 -> cpu_run=0; then start, 0x77 -> err_cmd=1 and no writes.
REQ-042 Repeated start with a byte in the same cycle during DATA, then 0xA5, 0x08, 0x99 -> the colliding byte is not written; a single write (8,0x99) occurs.
REQ-043 rst pulsed between two data bytes -> all outputs zero immediately; subsequent data bytes with no new start produce no mem_we.
